// File: rtl/m_game_controller_if.sv
// Move handshake and board-status bundle between a host and m_game_controller.
interface m_game_controller_if;
  localparam int unsigned FIELD_SIZE = 42;

  logic                  i_new_game;
  logic                  i_move_valid;
  logic [2:0]            i_move_col;
  logic                  o_move_ready;
  logic                  o_move_done;
  logic                  o_move_reject;
  logic [FIELD_SIZE-1:0] o_field_p1;
  logic [FIELD_SIZE-1:0] o_field_p2;
  logic                  o_turn;
  logic                  o_game_over;
  logic [1:0]            o_winner;

  modport master (
    output i_new_game, i_move_valid, i_move_col,
    input  o_move_ready, o_move_done, o_move_reject,
    input  o_field_p1, o_field_p2, o_turn, o_game_over, o_winner
  );

  modport slave (
    input  i_new_game, i_move_valid, i_move_col,
    output o_move_ready, o_move_done, o_move_reject,
    output o_field_p1, o_field_p2, o_turn, o_game_over, o_winner
  );
endinterface

// File: rtl/m_game_controller.sv
// Connect-four referee: gravity drop per column, shared four-in-a-row detector,
// turn/winner bookkeeping. Cell (r,c) lives at bit 7*r + (6-c), row 0 at the bottom.
module m_winning_detector (
  input  logic [41:0] i_field,
  output logic        o_win_c
);
  localparam int unsigned ROWS = 6;
  localparam int unsigned COLS = 7;
  localparam int unsigned CELLS = ROWS * COLS;

  logic [CELLS-1:0] hit_h, hit_v, hit_d, hit_a;

  // One anchor per cell; each direction is only built where four cells fit on the board.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int unsigned B = 7 * r + 6 - c;
      localparam int unsigned A = 7 * r + c;
      if (c <= 3) begin : g_h
        assign hit_h[A] = &{i_field[B], i_field[B-1], i_field[B-2], i_field[B-3]};
      end else begin : g_nh
        assign hit_h[A] = 1'b0;
      end
      if (r <= 2) begin : g_v
        assign hit_v[A] = &{i_field[B], i_field[B+7], i_field[B+14], i_field[B+21]};
      end else begin : g_nv
        assign hit_v[A] = 1'b0;
      end
      if (r <= 2 && c <= 3) begin : g_d
        assign hit_d[A] = &{i_field[B], i_field[B+6], i_field[B+12], i_field[B+18]};
      end else begin : g_nd
        assign hit_d[A] = 1'b0;
      end
      if (r <= 2 && c >= 3) begin : g_a
        assign hit_a[A] = &{i_field[B], i_field[B+8], i_field[B+16], i_field[B+24]};
      end else begin : g_na
        assign hit_a[A] = 1'b0;
      end
    end
  end

  assign o_win_c = |{hit_h, hit_v, hit_d, hit_a};
endmodule

module m_game_controller (
  input  logic                i_clk,
  input  logic                i_rst,
  m_game_controller_if.slave  bus
);
  localparam int unsigned FIELD_SIZE = 42;
  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [2:0]            col, col_nxt;
  logic [2:0]            row_cnt, row_nxt;
  logic [5:0]            move_cnt, move_cnt_nxt;
  logic [FIELD_SIZE-1:0] field_p1, p1_nxt, field_p2, p2_nxt;
  logic                  turn, turn_nxt;
  logic [1:0]            winner, winner_nxt;
  logic                  game_over, game_over_nxt;
  logic                  move_ready, ready_nxt;
  logic                  move_done, done_nxt;
  logic                  move_reject, reject_nxt;

  logic [FIELD_SIZE-1:0] occ_field, cell_mask, det_field;
  logic [5:0]            cell_idx;
  logic                  cell_busy, win_c;

  assign occ_field = field_p1 | field_p2;
  assign cell_idx  = 6'(row_cnt) * 6'd7 + 6'(3'd6 - col);
  assign cell_busy = occ_field[cell_idx];
  assign cell_mask = FIELD_SIZE'(1) << cell_idx;
  assign det_field = turn ? field_p2 : field_p1;

  m_winning_detector u_win (
    .i_field (det_field),
    .o_win_c (win_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_WAIT;
      col         <= '0;
      row_cnt     <= '0;
      move_cnt    <= '0;
      field_p1    <= '0;
      field_p2    <= '0;
      turn        <= 1'b0;
      winner      <= 2'b00;
      game_over   <= 1'b0;
      move_ready  <= 1'b1;
      move_done   <= 1'b0;
      move_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      col         <= col_nxt;
      row_cnt     <= row_nxt;
      move_cnt    <= move_cnt_nxt;
      field_p1    <= p1_nxt;
      field_p2    <= p2_nxt;
      turn        <= turn_nxt;
      winner      <= winner_nxt;
      game_over   <= game_over_nxt;
      move_ready  <= ready_nxt;
      move_done   <= done_nxt;
      move_reject <= reject_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    col_nxt      = col;
    row_nxt      = row_cnt;
    move_cnt_nxt = move_cnt;
    p1_nxt       = field_p1;
    p2_nxt       = field_p2;
    turn_nxt     = turn;
    winner_nxt   = winner;
    done_nxt     = 1'b0;
    reject_nxt   = 1'b0;

    if (bus.i_new_game) begin
      // Restart wins over everything, including a half-finished drop.
      state_nxt    = S_WAIT;
      row_nxt      = '0;
      move_cnt_nxt = '0;
      p1_nxt       = '0;
      p2_nxt       = '0;
      turn_nxt     = 1'b0;
      winner_nxt   = 2'b00;
    end else begin
      case (state)
        S_WAIT: begin
          if (bus.i_move_valid && move_ready) begin
            if (bus.i_move_col == 3'd7) begin
              reject_nxt = 1'b1;
            end else begin
              col_nxt   = bus.i_move_col;
              row_nxt   = '0;
              state_nxt = S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (!cell_busy) begin
            if (turn) p2_nxt = field_p2 | cell_mask;
            else      p1_nxt = field_p1 | cell_mask;
            state_nxt = S_CHECK;
          end else if (row_cnt == 3'd5) begin
            reject_nxt = 1'b1;
            state_nxt  = S_WAIT;
          end else begin
            row_nxt = row_cnt + 3'd1;
          end
        end
        S_CHECK: begin
          move_cnt_nxt = move_cnt + 6'd1;
          done_nxt     = 1'b1;
          if (win_c) begin
            winner_nxt = turn ? 2'b10 : 2'b01;
            state_nxt  = S_OVER;
          end else if (move_cnt == 6'd41) begin
            winner_nxt = 2'b11;
            state_nxt  = S_OVER;
          end else begin
            turn_nxt  = ~turn;
            state_nxt = S_WAIT;
          end
        end
        default: begin
          state_nxt = S_OVER;
        end
      endcase
    end

    ready_nxt     = (state_nxt == S_WAIT);
    game_over_nxt = (state_nxt == S_OVER);
  end

  assign bus.o_move_ready  = move_ready;
  assign bus.o_move_done   = move_done;
  assign bus.o_move_reject = move_reject;
  assign bus.o_field_p1    = field_p1;
  assign bus.o_field_p2    = field_p2;
  assign bus.o_turn        = turn;
  assign bus.o_game_over   = game_over;
  assign bus.o_winner      = winner;
endmodule

// File: tb/tb_m_game_controller.sv
// Scoreboarded bench for m_game_controller: board model with gravity and line search.
module tb_m_game_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  m_game_controller_if bus ();

  m_game_controller dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    int          kind;      // 0 = done, 1 = reject
    int unsigned t_exp;
    logic [41:0] p1;
    logic [41:0] p2;
    logic        turn;
    logic [1:0]  winner;
    logic        over;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference board: 0 empty, 1 = P1, 2 = P2.
  int board [6][7];
  int height [7];
  int m_turn;
  int m_winner;
  bit m_over;
  int m_moves;

  function automatic void model_reset();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) board[r][c] = 0;
    for (int c = 0; c < 7; c++) height[c] = 0;
    m_turn = 0; m_winner = 0; m_over = 1'b0; m_moves = 0;
  endfunction

  function automatic logic [41:0] model_field(input int p);
    logic [41:0] f = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if (board[r][c] == p) f[7*r + 6 - c] = 1'b1;
    return f;
  endfunction

  function automatic bit model_win(input int p);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        for (int d = 0; d < 4; d++) begin
          bit ok = 1'b1;
          for (int i = 0; i < 4; i++) begin
            int rr = r + dr[d] * i;
            int cc = c + dc[d] * i;
            if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 1'b0;
            else if (board[rr][cc] != p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_model(input string name);
    check({name, "_p1"},     64'(bus.o_field_p1),   64'(model_field(1)));
    check({name, "_p2"},     64'(bus.o_field_p2),   64'(model_field(2)));
    check({name, "_turn"},   64'(bus.o_turn),       64'(m_turn));
    check({name, "_winner"}, 64'(bus.o_winner),     64'(m_winner));
    check({name, "_over"},   64'(bus.o_game_over),  64'(m_over));
    check({name, "_ready"},  64'(bus.o_move_ready), 64'(!m_over));
  endtask

  task automatic check_idle(input string name);
    check({name, "_p1"},     64'(bus.o_field_p1),    64'd0);
    check({name, "_p2"},     64'(bus.o_field_p2),    64'd0);
    check({name, "_turn"},   64'(bus.o_turn),        64'd0);
    check({name, "_winner"}, 64'(bus.o_winner),      64'd0);
    check({name, "_over"},   64'(bus.o_game_over),   64'd0);
    check({name, "_ready"},  64'(bus.o_move_ready),  64'd1);
    check({name, "_done"},   64'(bus.o_move_done),   64'd0);
    check({name, "_reject"}, 64'(bus.o_move_reject), 64'd0);
  endtask

  // Monitor: every done/reject pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      check("no_overlap", 64'(bus.o_field_p1 & bus.o_field_p2), 64'd0);
      if (bus.o_move_done || bus.o_move_reject) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse done=%0b reject=%0b required=none (t=%0t)",
                   bus.o_move_done, bus.o_move_reject, $time);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_kind", 64'({bus.o_move_done, bus.o_move_reject}),
                64'((mon_e.kind == 0) ? 2'b10 : 2'b01));
          check("latency",    64'(cyc),               64'(mon_e.t_exp));
          check("resp_p1",    64'(bus.o_field_p1),    64'(mon_e.p1));
          check("resp_p2",    64'(bus.o_field_p2),    64'(mon_e.p2));
          check("resp_turn",  64'(bus.o_turn),        64'(mon_e.turn));
          check("resp_win",   64'(bus.o_winner),      64'(mon_e.winner));
          check("resp_over",  64'(bus.o_game_over),   64'(mon_e.over));
          check("resp_ready", 64'(bus.o_move_ready),  64'(!mon_e.over));
        end
      end
    end
  end

  // All driver tasks start and end one time unit after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_move(input int c);
    exp_t e;
    int lat;
    int mover;
    bit landed;
    int unsigned t0;
    for (int i = 0; i < 40 && !bus.o_move_ready; i++) step();
    check("ready_before_move", 64'(bus.o_move_ready), 64'd1);
    mover  = m_turn;
    landed = 1'b0;
    if (c > 6) begin
      lat = 1; e.kind = 1;
    end else if (height[c] == 6) begin
      lat = 7; e.kind = 1;
    end else begin
      lat = 3 + height[c];
      e.kind = 0;
      landed = 1'b1;
      board[height[c]][c] = mover + 1;
      height[c]++;
      m_moves++;
      if (model_win(mover + 1)) begin
        m_winner = mover + 1; m_over = 1'b1;
      end else if (m_moves == 42) begin
        m_winner = 3; m_over = 1'b1;
      end else begin
        m_turn = 1 - m_turn;
      end
    end
    e.p1 = model_field(1); e.p2 = model_field(2);
    e.turn = 1'(m_turn); e.winner = 2'(m_winner); e.over = m_over;
    bus.i_move_valid = 1'b1;
    bus.i_move_col   = 3'(c);
    t0 = cyc;
    e.t_exp = t0 + 32'(lat);
    sb.push_back(e);
    step();
    bus.i_move_valid = 1'b0;
    if (landed) begin
      while (cyc < t0 + 32'(lat) - 1) step();
      check("land_field", 64'(mover ? bus.o_field_p2 : bus.o_field_p1),
            64'(mover ? e.p2 : e.p1));
      check("done_not_early", 64'(bus.o_move_done), 64'd0);
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL response_timeout col=%0d pending=%0d required=0", c, sb.size());
      sb.delete();
    end
  endtask

  task automatic new_game();
    bus.i_new_game = 1'b1;
    sb.delete();
    model_reset();
    step();
    bus.i_new_game = 1'b0;
    check_idle("new_game");
  endtask

  task automatic play(input int seq[], input int n);
    for (int i = 0; i < n; i++) do_move(seq[i]);
  endtask

  int draw_seq [42];
  int pair_a [3] = '{0, 1, 4};
  int pair_b [3] = '{2, 3, 6};
  int zig [12]   = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
  int win1 [7]   = '{1, 1, 2, 2, 3, 0, 0};
  int win2 [8]   = '{0, 1, 0, 1, 0, 1, 2, 1};

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_new_game   = 1'b0;
    bus.i_move_valid = 1'b0;
    bus.i_move_col   = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset");

    // First move lands at bit 6; then P1 completes a bottom-row four.
    do_move(0);
    check("first_move_turn", 64'(bus.o_turn), 64'd1);
    win1[5] = 1; win1[6] = 1;
    do_move(0); do_move(1); do_move(1); do_move(2); do_move(2); do_move(3);
    check("p1_win_winner", 64'(bus.o_winner), 64'd1);
    bus.i_move_valid = 1'b1; bus.i_move_col = 3'd4;
    repeat (4) step();
    bus.i_move_valid = 1'b0;
    check_model("over_hold");

    // Fill column 2, then a seventh drop is refused.
    new_game();
    repeat (7) do_move(2);
    check_model("after_full");

    // Illegal column, then restart aborts a drop in flight.
    do_move(7);
    bus.i_move_valid = 1'b1; bus.i_move_col = 3'd3;
    step();
    bus.i_move_valid = 1'b0; bus.i_new_game = 1'b1;
    sb.delete(); model_reset();
    step();
    bus.i_new_game = 1'b0;
    check_idle("abort_scan");
    repeat (8) step();
    check_idle("abort_quiet");

    // Restart coinciding with a handshake: move discarded, no reject.
    bus.i_move_valid = 1'b1; bus.i_move_col = 3'd7; bus.i_new_game = 1'b1;
    step();
    bus.i_move_valid = 1'b0; bus.i_new_game = 1'b0;
    check_idle("coincide");
    repeat (3) step();

    // Full board with no line anywhere.
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 12; i++)
        draw_seq[12*p + i] = zig[i] ? pair_b[p] : pair_a[p];
    for (int i = 36; i < 42; i++) draw_seq[i] = 5;
    play(draw_seq, 42);
    check("draw_winner", 64'(bus.o_winner), 64'd3);
    check_model("draw");

    new_game();
    play(win2, 8);
    check("p2_win_winner", 64'(bus.o_winner), 64'd2);
    check_model("p2_win");

    for (int g = 0; g < 5; g++) begin
      new_game();
      for (int m = 0; m < 70 && !m_over; m++) do_move(int'($urandom_range(7, 0)));
      check_model("random_end");
    end

    // Reset in the middle of a drop.
    new_game();
    do_move(0); do_move(0);
    bus.i_move_valid = 1'b1; bus.i_move_col = 3'd0;
    step();
    bus.i_move_valid = 1'b0; rst = 1'b1;
    sb.delete(); model_reset();
    step();
    rst = 1'b0;
    check_idle("reset_mid_scan");
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_game_controller.md
M_GAME_CONTROLLER -- requirements
Module: m_game_controller

Interface
- Parameters: none. Field width is `FIELD_SIZE` (42) from config.vh, organised as 6 rows x 7 columns.
- REQ-001 i_clk  in  1  Sole clock; all state SHALL update on the rising edge.
- REQ-002 i_rst  in  1  Reset, synchronous, active-high.
- REQ-003 i_new_game  in  1  Level-sampled request to restart the game.
- REQ-004 i_move_valid  in  1  Move request, qualified by o_move_ready.
- REQ-005 i_move_col  in  3  Target column, 0..6; values 7 are illegal.
- REQ-006 o_move_ready  out  1  High only in S_WAIT.
- REQ-007 o_move_done  out  1  One-cycle pulse when a move is committed and evaluated.
- REQ-008 o_move_reject  out  1  One-cycle pulse for an illegal column or a full column.
- REQ-009 o_field_p1  out  42  Player-1 occupancy, registered.
- REQ-010 o_field_p2  out  42  Player-2 occupancy, registered.
- REQ-011 o_turn  out  1  Player to move: 0 = P1, 1 = P2.
- REQ-012 o_game_over  out  1  High in S_OVER.
- REQ-013 o_winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

Function
- REQ-014 Bit mapping SHALL be: cell (row r, col c) = bit 7*r + (6-c); row 0 (bits [6:0]) is the bottom row and column 0 is the MSB of each 7-bit row group.
- REQ-015 The block SHALL contain exactly one m_winning_detector instance, shared between players; its i_field SHALL be o_field_p1 when o_turn = 0, else o_field_p2.
- REQ-016 The FSM SHALL have the states S_WAIT, S_SCAN, S_CHECK and S_OVER.
- REQ-017 In S_WAIT, a handshake (i_move_valid & o_move_ready) with i_move_col > 6 SHALL pulse o_move_reject on the next cycle, stay in S_WAIT, and leave o_turn unchanged.
- REQ-018 In S_WAIT, a handshake with a legal column SHALL latch the column, clear the 3-bit row counter, and go to S_SCAN.
- REQ-019 In S_SCAN, each cycle SHALL test cell (row_cnt, col) in (p1|p2); if the cell is empty, the cycle SHALL set that bit in the mover's field and go to S_CHECK.
- REQ-020 In S_SCAN, if the cell is occupied and row_cnt < 5, row_cnt SHALL increment.
- REQ-021 In S_SCAN, if the cell is occupied and row_cnt = 5 (column full), the block SHALL pulse o_move_reject, return to S_WAIT, and leave the fields and o_turn unchanged.
- REQ-022 S_CHECK SHALL last one cycle, increment the 6-bit move counter, and pulse o_move_done on the following cycle.
- REQ-023 In S_CHECK, if the detector fires, the block SHALL go to S_OVER with o_winner = mover (01/10) and leave o_turn unchanged.
- REQ-024 In S_CHECK, otherwise, if the move counter becomes 42, the block SHALL go to S_OVER with o_winner = 11.
- REQ-025 In S_CHECK, otherwise, the block SHALL toggle o_turn and return to S_WAIT.
- REQ-026 Latency: for a handshake at cycle T landing in row k, the bit SHALL be visible at T+2+k, and o_move_done, the new o_turn/o_winner and o_move_ready SHALL all be visible at T+3+k.
- REQ-027 A reject SHALL be visible at T+1 for an illegal column, and at T+7 for a full column, with o_move_ready back high that same cycle.
- REQ-028 i_move_valid outside S_WAIT SHALL be ignored, with no queuing.
- REQ-029 S_OVER SHALL hold all outputs until i_new_game is asserted.
- REQ-030 i_new_game in any state SHALL, on the next edge, clear both fields, o_turn, o_winner and the move counter, and enter S_WAIT; it SHALL abort any in-progress S_SCAN or S_CHECK without committing.
- REQ-031 When i_new_game and a handshake coincide, i_new_game SHALL win and the move SHALL be discarded without a reject.
- REQ-032 o_field_p1 & o_field_p2 SHALL be 0 at all times.

Reset
- REQ-033 While i_rst = 1 at an edge, the block SHALL set state = S_WAIT, both fields = 0, o_turn = 0, o_winner = 00, o_game_over = 0, o_move_done = 0, o_move_reject = 0, and clear the counters.
- REQ-034 i_rst SHALL take priority over i_new_game and move handshakes.
- REQ-035 o_move_ready SHALL be 1 on the first cycle after reset release.

Verification
- REQ-036 After reset, a move to col 0 -> o_field_p1 = bit 6 set at T+2, o_move_done and o_turn = 1 at T+3.
- REQ-037 Alternate moves P1 col 0..3 and P2 col 0..2 -> o_winner = 01, o_game_over = 1, further i_move_valid ignored, o_turn stays 0.
- REQ-038 Fill col 2 with 6 moves, then a 7th move to col 2 -> o_move_reject at T+7, fields unchanged, o_turn unchanged.
- REQ-039 i_move_col = 7 -> reject at T+1, no field change; then i_new_game during S_SCAN -> both fields = 0 and S_WAIT on the next cycle.
- REQ-040 A non-winning 42-move sequence -> o_winner = 11 after the last o_move_done; a P2 vertical four -> o_winner = 10.
- REQ-041 i_rst asserted mid-S_SCAN -> all outputs at reset values on the next cycle; the fields are never both set in the same bit.
